ring_osc_freq_meter: RTL

Measures the frequency of one ring-oscillator output against the system clock. It enables the ring, synchronizes the free-running oscillator signal into the clock domain, and counts its rising edges over a fixed gate window. It then reports the edge count and a completion pulse. The block is the measurement end of the ring-oscillator outputs: its `en_osc` drives a ring's enable input, and that ring's output returns on `osc_in`.

---
 rtl/ring_osc_meas_pkg.sv | 20 ++
 rtl/osc_edge_sync.sv | 27 ++
 rtl/ring_osc_freq_meter.sv | 118 +++++++++++
 3 files changed

// File: rtl/ring_osc_meas_pkg.sv
// Shared types and default constants for the ring-oscillator frequency meter.
// The phase timer is sized from the larger of the two phase lengths via max_int.
package ring_osc_meas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } meas_state_e;

  localparam int DEF_GATE_CYCLES   = 50000;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_SYNC_STAGES   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the free-running oscillator into the clk domain and flags its rising edges.
// The chain runs in every state so stale samples are flushed before a gate opens.
module osc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Enables a ring oscillator, waits for it to settle, then counts its rising edges
// over a fixed gate window and publishes the count with a one-cycle done pulse.
module ring_osc_freq_meter
  import ring_osc_meas_pkg::*;
#(
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             osc_in,
  output logic             en_osc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int TMR_W = $clog2(max_int(SETTLE_CYCLES, GATE_CYCLES) + 1);

  // Handshake: start is a request seen only in IDLE (no queueing); done is a
  // single-cycle strobe meaning count/overflow were just refreshed.
  meas_state_e        state, next_state;
  logic [TMR_W-1:0]   tmr;
  logic               tmr_zero;
  logic               rise;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               sat, sat_nxt;
  logic               gate_entry;
  logic               gate_exit;

  osc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_in (osc_in),
    .rise   (rise)
  );

  assign tmr_zero = (tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // stop outranks every transition, including GATE -> DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)    next_state = SETTLE;
      SETTLE:  if (tmr_zero) next_state = GATE;
      GATE:    if (tmr_zero) next_state = DONE;
      DONE:                  next_state = IDLE;
      default:               next_state = IDLE;
    endcase
    if (stop) next_state = IDLE;
  end

  assign gate_entry = (state == SETTLE) && (next_state == GATE);
  assign gate_exit  = (state == GATE)   && (next_state == DONE);

  // Down-counter reloaded on each phase entry; a phase ends when it reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if ((state == IDLE) && (next_state == SETTLE)) begin
      tmr <= TMR_W'(SETTLE_CYCLES - 1);
    end else if (gate_entry) begin
      tmr <= TMR_W'(GATE_CYCLES - 1);
    end else if (!tmr_zero) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    sat_nxt = sat;
    if ((state == GATE) && rise) begin
      if (&cnt) sat_nxt = 1'b1;
      else      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (gate_entry) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= sat_nxt;
    end
  end

  // The final gate cycle's edge is included by loading the next-value terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (gate_exit) begin
      count    <= cnt_nxt;
      overflow <= sat_nxt;
    end
  end

  assign en_osc = (state == SETTLE) || (state == GATE);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule
